dsc_mul_seq: RTL and testbench

//   Upstream sequencer for the deterministic stochastic-computing multiplier dsc_mul (3 operands, serial).
//   - Accepts operand triples over a valid/ready handshake and holds them stable into dsc_mul.
//   - Drives dsc_mul's rst/en, waits for its ov (done) flag, then captures z.
//   - Returns z plus a per-operation run-cycle count over a valid/ready handshake.

---
 rtl/dsc_mul_seq.sv | 144 ++++++++++++++
 tb/tb_dsc_mul_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: operand/result sequencer wrapped around the serial dsc_mul.
// Optional DSC_SEQ_ZERO_BYPASS_EN: zero operands skip dsc_mul (CLR -> HOLD).
module dsc_mul_seq #(
  parameter int NUM_BITS = 4,
  parameter int CYC_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_BITS-1:0]     in_a,
  input  logic [NUM_BITS-1:0]     in_b,
  input  logic [NUM_BITS-1:0]     in_c,
  output logic                    mul_rst,
  output logic                    mul_en,
  output logic [NUM_BITS-1:0]     mul_a,
  output logic [NUM_BITS-1:0]     mul_b,
  output logic [NUM_BITS-1:0]     mul_c,
  input  logic [3*NUM_BITS-1:0]   mul_z,
  input  logic                    mul_ov,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3*NUM_BITS-1:0]   out_z,
  output logic [CYC_W-1:0]        out_cycles,
  output logic                    busy
);

  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    HOLD
  } state_t;

  state_t           state;
  logic [CYC_W-1:0] cnt;
  logic [CYC_W-1:0] cnt_inc;

  // Saturating next value of the run counter.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != CYC_MAX) cnt_inc = cnt + CYC_W'(1);
  end

`ifdef DSC_SEQ_ZERO_BYPASS_EN
  logic any_zero;

  // A zero operand makes the product zero without running dsc_mul.
  always_comb begin
    any_zero = (mul_a == '0) || (mul_b == '0) || (mul_c == '0);
  end
`endif

  // Sequencer FSM; every output is a register set alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      mul_rst    <= 1'b1;
      mul_en     <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_c      <= '0;
      out_valid  <= 1'b0;
      out_z      <= '0;
      out_cycles <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          mul_rst  <= 1'b1;
          mul_en   <= 1'b0;
          if (in_valid && in_ready) begin
            mul_a    <= in_a;
            mul_b    <= in_b;
            mul_c    <= in_c;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CLR;
          end
        end
        CLR: begin
          cnt <= '0;
`ifdef DSC_SEQ_ZERO_BYPASS_EN
          if (any_zero) begin
            mul_rst    <= 1'b0;
            out_z      <= '0;
            out_cycles <= '0;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end else begin
            mul_rst <= 1'b0;
            mul_en  <= 1'b1;
            state   <= RUN;
          end
`else
          mul_rst <= 1'b0;
          mul_en  <= 1'b1;
          state   <= RUN;
`endif
        end
        RUN: begin
          cnt <= cnt_inc;
          if (mul_ov) begin
            out_z      <= mul_z;
            out_cycles <= cnt_inc;
            out_valid  <= 1'b1;
            mul_en     <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            mul_rst   <= 1'b1;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Structural invariants between state and handshake outputs.
  a_en_run: assert property (
    @(posedge clk) disable iff (!rst)
    mul_en |-> (state == RUN));

  a_ov_hold: assert property (
    @(posedge clk) disable iff (!rst)
    out_valid |-> (state == HOLD));

  a_rdy_idle: assert property (
    @(posedge clk) disable iff (!rst)
    in_ready |-> (state == IDLE));

endmodule

// File: tb/tb_dsc_mul_seq.sv
// tb_dsc_mul_seq: scoreboard bench for dsc_mul_seq.
// Uses a latency-programmable stand-in for dsc_mul.
module tb_dsc_mul_seq;

  localparam int NB = 4;
  localparam int CW = 5;
  localparam int ZW = 3 * NB;
  localparam int CMAX = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_a, in_b, in_c;
  logic          mul_rst, mul_en;
  logic [NB-1:0] mul_a, mul_b, mul_c;
  logic [ZW-1:0] mul_z;
  logic          mul_ov;
  logic          out_valid, out_ready;
  logic [ZW-1:0] out_z;
  logic [CW-1:0] out_cycles;
  logic          busy;

  always #5 clk = ~clk;

  dsc_mul_seq #(.NUM_BITS(NB), .CYC_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .mul_rst(mul_rst), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .mul_z(mul_z), .mul_ov(mul_ov),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_cycles(out_cycles),
    .busy(busy)
  );

  // dsc_mul stand-in: ov rises after lat enabled cycles
  int model_lat = 3;
  int k = 0;
  int lat_q = 0;

  always @(posedge clk) begin
    if (mul_rst) begin
      k     <= 0;
      lat_q <= model_lat;
    end else if (mul_en && k < 1000) begin
      k <= k + 1;
    end
  end

  assign mul_ov = !mul_rst && (k >= lat_q);
  assign mul_z  = mul_ov ? ZW'(mul_a) * ZW'(mul_b) * ZW'(mul_c) : '0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [ZW-1:0] z;
    int            cyc;
  } exp_t;

  exp_t q[$];

  int cyc = 0;
  int acc_cyc = 0;
  int hs_cyc = -100;
  int acc_gap = 0;
  int ov_gap = 0;
  int en_cnt = 0;
  logic prev_ov = 1'b0;
  logic [NB-1:0] la = '0, lb = '0, lc = '0;

  // monitor: push on accept, pop/compare on output handshake
  always @(negedge clk) begin
    exp_t e;
    logic zero;
    int sat;
    cyc++;
    if (rst) begin
      if (mul_en) en_cnt++;
      if (out_valid && !prev_ov) ov_gap = cyc - acc_cyc;
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        zero = (in_a == 0) || (in_b == 0) || (in_c == 0);
        sat = (model_lat + 1 > CMAX) ? CMAX : model_lat + 1;
        e.z = ZW'(in_a) * ZW'(in_b) * ZW'(in_c);
`ifdef DSC_SEQ_ZERO_BYPASS_EN
        e.cyc = zero ? 0 : sat;
`else
        e.cyc = sat;
`endif
        q.push_back(e);
        la = in_a; lb = in_b; lc = in_c;
        en_cnt = 0;
        acc_gap = cyc - hs_cyc;
        acc_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        hs_cyc = cyc;
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_z", out_z, e.z);
          chk("out_cycles", out_cycles, e.cyc);
          chk("cyc_vs_en", out_cycles,
              (en_cnt > CMAX) ? CMAX : en_cnt);
          chk("mul_hold", {mul_a, mul_b, mul_c}, {la, lb, lc});
        end
      end
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [NB-1:0] a, b, c, input int lat);
    int n;
    step();
    model_lat = lat;
    in_a = a; in_b = b; in_c = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      step();
      n++;
    end
    if (!out_valid) chk("ov_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((busy || out_valid || q.size() != 0) && n < 400) begin
      step();
      n++;
    end
    if (busy || out_valid || q.size() != 0) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_out_valid"}, out_valid, 0);
    chk({t, "_out_z"}, out_z, 0);
    chk({t, "_out_cycles"}, out_cycles, 0);
    chk({t, "_mul_en"}, mul_en, 0);
    chk({t, "_mul_rst"}, mul_rst, 1);
    chk({t, "_mul_abc"}, {mul_a, mul_b, mul_c}, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    logic [ZW-1:0] z0;
    logic [CW-1:0] c0;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset("rst");
    repeat (3) step();
    rst = 1'b1;

    // 1: max operands, single-cycle out_valid pulse
    out_ready = 1'b1;
    send(4'd15, 4'd15, 4'd15, 4);
    wait_ov();
    chk("t1_z", out_z, 3375);
    step();
    chk("t1_pulse", out_valid, 0);
    wait_done();

    // 2: backpressure keeps result stable
    out_ready = 1'b0;
    send(4'd3, 4'd5, 4'd7, 2);
    wait_ov();
    z0 = out_z;
    c0 = out_cycles;
    chk("t2_z", z0, 105);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_valid", out_valid, 1);
      chk("t2_stable", {out_z, out_cycles}, {z0, c0});
      chk("t2_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    wait_done();

    // 3: back-to-back triples with in_valid held
    step();
    model_lat = 1;
    in_a = 4'd2; in_b = 4'd2; in_c = 4'd2;
    in_valid = 1'b1;
    for (int n = 0; n < 300 && !in_ready; n++) step();
    step();
    in_a = 4'd15; in_b = 4'd1; in_c = 4'd9;
    for (int n = 0; n < 300 && !in_ready; n++) step();
    chk("t3_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    wait_done();
    chk("t3_gap", acc_gap, 1);

    // 4: asynchronous reset during RUN
    send(4'd9, 4'd9, 4'd9, 20);
    repeat (4) step();
    chk("t4_in_run", mul_en, 1);
    rst = 1'b0;
    #1 chk_reset("t4");
    q.delete();
    step();
    step();
    rst = 1'b1;
    send(4'd4, 4'd4, 4'd4, 3);
    wait_done();

    // 5: zero operand
    send(4'd0, 4'd9, 4'd4, 3);
    wait_done();
`ifdef DSC_SEQ_ZERO_BYPASS_EN
    chk("t5_ov_gap", ov_gap, 2);
    chk("t5_no_en", en_cnt, 0);
`else
    chk("t5_en_cnt", en_cnt, 4);
`endif

    // 6: new triple ignored while RUN is in progress
    send(4'd6, 4'd7, 4'd8, 10);
    repeat (2) step();
    model_lat = 2;
    in_a = 4'd1; in_b = 4'd1; in_c = 4'd1;
    in_valid = 1'b1;
    step();
    chk("t6_mul_abc", {mul_a, mul_b, mul_c}, {4'd6, 4'd7, 4'd8});
    chk("t6_busy", busy, 1);
    for (int n = 0; n < 300 && !in_ready; n++) step();
    step();
    in_valid = 1'b0;
    chk("t6_gap", acc_gap, 1);
    wait_done();

    // counter saturation and ov in the first RUN cycle
    send(4'd2, 4'd3, 4'd4, 40);
    wait_done();
    send(4'd5, 4'd5, 4'd5, 0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
